// File: rtl/pe_stream_feeder.sv
// ----------------------------------------------------------------------------
// pe_stream_feeder
//   Multi-channel burst source for PE input ports (fmap, weight, psum).
//   Each channel has its own FSM. The FSM sends `bursts` bursts of `len`
//   beats and inserts `gap` idle cycles between bursts. It talks to the sink
//   with a valid/ready handshake, and the transfer strobe (valid & ready)
//   drives the PE *_in_en input directly.
//
//   Data source: an incrementing counter by default. When FEEDER_PRBS_EN is
//   defined, each channel instead runs a 16-bit Fibonacci LFSR
//   (x^16+x^14+x^13+x^11+1) in the low 16 bits, and the upper bits read 0.
//   That build needs DATA_WIDTH >= 16.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   clr         synchronous soft clear of all channels (beats start/transfer)
//   ch_start    per-channel start pulse (ignored unless channel is idle)
//   ch_base     per-channel first data value / LFSR seed
//   ch_len      per-channel beats per burst
//   ch_bursts   per-channel burst count
//   ch_gap      per-channel idle cycles between bursts
//   ch_ready    per-channel sink ready
//   ch_data     per-channel registered data word
//   ch_valid    per-channel data valid
//   ch_en       per-channel transfer strobe (ch_valid & ch_ready)
//   ch_busy     per-channel SEND/GAP/DONE indicator
//   ch_done     per-channel one-cycle pulse after the last beat
// ----------------------------------------------------------------------------

module pe_stream_feeder_ch #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [CNT_WIDTH-1:0]  len,
    input  logic [CNT_WIDTH-1:0]  bursts,
    input  logic [GAP_WIDTH-1:0]  gap,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  en,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  beat_rem;
    logic [CNT_WIDTH-1:0]  burst_rem;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [GAP_WIDTH-1:0]  gap_rem;

    logic                  xfer;
    logic [DATA_WIDTH-1:0] data_next;
    logic [DATA_WIDTH-1:0] data_seed;

`ifdef FEEDER_PRBS_EN
    // A zero seed would lock the LFSR at zero, so force it to 1.
    always_comb begin
        data_seed       = '0;
        data_seed[15:0] = (base[15:0] == 16'h0) ? 16'h0001 : base[15:0];
    end

    // Fibonacci step: taps 16,14,13,11 are bits 15,13,12,10, shifted in at the LSB.
    always_comb begin
        data_next       = '0;
        data_next[15:0] = {data_q[14:0], data_q[15] ^ data_q[13] ^ data_q[12] ^ data_q[10]};
    end
`else
    assign data_seed = base;
    assign data_next = data_q + 1'b1;
`endif

    assign xfer  = (state == S_SEND) && ready;

    // All outputs decode from registers. ready only reaches the combinational strobe.
    assign data  = data_q;
    assign valid = (state == S_SEND);
    assign en    = valid & ready;
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            data_q    <= '0;
            len_q     <= '0;
            beat_rem  <= '0;
            burst_rem <= '0;
            gap_q     <= '0;
            gap_rem   <= '0;
        end else if (clr) begin
            state     <= S_IDLE;
            data_q    <= '0;
            len_q     <= '0;
            beat_rem  <= '0;
            burst_rem <= '0;
            gap_q     <= '0;
            gap_rem   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        gap_q     <= gap;
                        beat_rem  <= len;
                        burst_rem <= bursts;
                        if (len == '0 || bursts == '0) begin
                            // Empty job: report completion without emitting beats.
                            state <= S_DONE;
                        end else begin
                            data_q <= data_seed;
                            state  <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        data_q <= data_next;
                        if (beat_rem == CNT_WIDTH'(1)) begin
                            if (burst_rem == CNT_WIDTH'(1)) begin
                                state <= S_DONE;
                            end else begin
                                burst_rem <= burst_rem - 1'b1;
                                beat_rem  <= len_q;
                                // A zero gap keeps SEND so the next burst follows with no bubble.
                                if (gap_q != '0) begin
                                    gap_rem <= gap_q;
                                    state   <= S_GAP;
                                end
                            end
                        end else begin
                            beat_rem <= beat_rem - 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    // gap_rem enters at gap (>=1), so GAP lasts exactly gap cycles.
                    if (gap_rem == GAP_WIDTH'(1)) begin
                        state <= S_SEND;
                    end else begin
                        gap_rem <= gap_rem - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

module pe_stream_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 3,
    parameter int CNT_WIDTH  = 8,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [NUM_CH-1:0]            ch_start,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_base,
    input  logic [NUM_CH*CNT_WIDTH-1:0]  ch_len,
    input  logic [NUM_CH*CNT_WIDTH-1:0]  ch_bursts,
    input  logic [NUM_CH*GAP_WIDTH-1:0]  ch_gap,
    input  logic [NUM_CH-1:0]            ch_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_valid,
    output logic [NUM_CH-1:0]            ch_en,
    output logic [NUM_CH-1:0]            ch_busy,
    output logic [NUM_CH-1:0]            ch_done
);

    // Channels are fully independent, with no shared arbitration.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pe_stream_feeder_ch #(
            .DATA_WIDTH(DATA_WIDTH),
            .CNT_WIDTH (CNT_WIDTH),
            .GAP_WIDTH (GAP_WIDTH)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .start (ch_start[i]),
            .base  (ch_base[i*DATA_WIDTH +: DATA_WIDTH]),
            .len   (ch_len[i*CNT_WIDTH +: CNT_WIDTH]),
            .bursts(ch_bursts[i*CNT_WIDTH +: CNT_WIDTH]),
            .gap   (ch_gap[i*GAP_WIDTH +: GAP_WIDTH]),
            .ready (ch_ready[i]),
            .data  (ch_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .valid (ch_valid[i]),
            .en    (ch_en[i]),
            .busy  (ch_busy[i]),
            .done  (ch_done[i])
        );
    end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// ----------------------------------------------------------------------------
// tb_pe_stream_feeder
//   Directed bench for pe_stream_feeder in its default (counter) build.
//   A table of single-channel jobs runs through a common cycle loop. Two
//   hand-written sequences then cover simultaneous starts, ignored restarts,
//   and async reset / soft clear.
// ----------------------------------------------------------------------------

module tb_pe_stream_feeder;

    localparam int DW = 16;
    localparam int NC = 3;
    localparam int CW = 8;
    localparam int GW = 8;

    logic               clk;
    logic               rst;
    logic               clr;
    logic [NC-1:0]      ch_start;
    logic [NC*DW-1:0]   ch_base;
    logic [NC*CW-1:0]   ch_len;
    logic [NC*CW-1:0]   ch_bursts;
    logic [NC*GW-1:0]   ch_gap;
    logic [NC-1:0]      ch_ready;
    logic [NC*DW-1:0]   ch_data;
    logic [NC-1:0]      ch_valid;
    logic [NC-1:0]      ch_en;
    logic [NC-1:0]      ch_busy;
    logic [NC-1:0]      ch_done;

    int total = 0;
    int bad   = 0;

    pe_stream_feeder #(
        .DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW), .GAP_WIDTH(GW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .ch_start (ch_start),
        .ch_base  (ch_base),
        .ch_len   (ch_len),
        .ch_bursts(ch_bursts),
        .ch_gap   (ch_gap),
        .ch_ready (ch_ready),
        .ch_data  (ch_data),
        .ch_valid (ch_valid),
        .ch_en    (ch_en),
        .ch_busy  (ch_busy),
        .ch_done  (ch_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         ch;
        logic [15:0] base;
        logic [7:0]  len;
        logic [7:0]  bursts;
        logic [7:0]  gap;
        bit          toggle;      // ready = 1,0,1,0... starting on cycle 1
        int          exp_beats;
        int          exp_done;    // cycle (1 = first after start edge) with ch_done high
        int          exp_novalid; // cycles before done with valid low
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    task automatic cfg(input int ch, input logic [15:0] base, input logic [7:0] len,
                       input logic [7:0] bursts, input logic [7:0] gap);
        ch_base[ch*DW +: DW]   = base;
        ch_len[ch*CW +: CW]    = len;
        ch_bursts[ch*CW +: CW] = bursts;
        ch_gap[ch*GW +: GW]    = gap;
    endtask

    // Starts one channel and follows it cycle by cycle until one cycle past done.
    task automatic run_vec(input int idx, input vec_t v);
        int nx, done_at, nov;
        bit shape_err, hold_err, fin;
        logic [15:0] last, prev_d, exp_d;
        logic prev_v, prev_en;
        nx = 0; done_at = -1; nov = 0; shape_err = 0; hold_err = 0; fin = 0;
        last = '0; prev_d = '0; prev_v = 1'b0; prev_en = 1'b0;
        cfg(v.ch, v.base, v.len, v.bursts, v.gap);
        ch_ready[v.ch] = 1'b1;
        ch_start[v.ch] = 1'b1;
        @(posedge clk); #1;
        ch_start[v.ch] = 1'b0;
        cfg(v.ch, 16'h5A5A, 8'd77, 8'd77, 8'd77);  // config is don't-care after start
        for (int c = 1; c <= 80 && !fin; c++) begin
            ch_ready[v.ch] = v.toggle ? c[0] : 1'b1;
            #1;
            if (done_at < 0) begin
                if (!ch_busy[v.ch]) shape_err = 1;
                if (prev_v && !prev_en &&
                    (!ch_valid[v.ch] || ch_data[v.ch*DW +: DW] !== prev_d)) hold_err = 1;
                if (ch_done[v.ch]) begin
                    done_at = c;
                    if (ch_valid[v.ch] || ch_en[v.ch]) shape_err = 1;
                end else if (!ch_valid[v.ch]) begin
                    nov++;
                end
                if (ch_en[v.ch]) begin
                    exp_d = v.base + 16'(nx);
                    chk($sformatf("v%0d_data%0d", idx, nx), ch_data[v.ch*DW +: DW], exp_d);
                    last = ch_data[v.ch*DW +: DW];
                    nx++;
                end
                prev_v  = ch_valid[v.ch];
                prev_en = ch_en[v.ch];
                prev_d  = ch_data[v.ch*DW +: DW];
            end else begin
                if (ch_busy[v.ch] || ch_valid[v.ch] || ch_done[v.ch]) shape_err = 1;
                fin = 1;
            end
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        chk($sformatf("v%0d_finished", idx), 32'(fin), 32'd1);
        chk($sformatf("v%0d_beats", idx), nx, v.exp_beats);
        chk($sformatf("v%0d_done_cycle", idx), done_at, v.exp_done);
        chk($sformatf("v%0d_novalid_cycles", idx), nov, v.exp_novalid);
        chk($sformatf("v%0d_shape_err", idx), 32'(shape_err), 32'd0);
        chk($sformatf("v%0d_hold_err", idx), 32'(hold_err), 32'd0);
        if (v.exp_beats > 0) chk($sformatf("v%0d_last", idx), last, v.exp_last);
        ch_ready = '1;
        @(posedge clk); #1;
    endtask

    initial begin
        bit          e2v[6];
        logic [15:0] e2d[6];
        bit          e2done[6];
        bit          e0v[6];
        bit          e0done[6];
        bit          e0busy[6];
        logic [15:0] e0d[6];
        int          n;

        vecs[0] = '{0, 16'd1,     8'd6, 8'd2, 8'd20, 1'b0, 12, 33, 20, 16'd12};
        vecs[1] = '{1, 16'd1,     8'd9, 8'd1, 8'd0,  1'b1,  9, 18,  0, 16'd9};
        vecs[2] = '{0, 16'd7,     8'd0, 8'd3, 8'd0,  1'b0,  0,  1,  0, 16'd0};
        vecs[3] = '{0, 16'd7,     8'd4, 8'd0, 8'd0,  1'b0,  0,  1,  0, 16'd0};
        vecs[4] = '{2, 16'hFFFE,  8'd4, 8'd1, 8'd0,  1'b0,  4,  5,  0, 16'h0001};
        vecs[5] = '{0, 16'd100,   8'd3, 8'd3, 8'd0,  1'b0,  9, 10,  0, 16'd108};
        vecs[6] = '{1, 16'd50,    8'd2, 8'd2, 8'd1,  1'b1,  4,  8,  1, 16'd53};

        rst = 1'b1; clr = 1'b0; ch_start = '0; ch_ready = '1;
        ch_base = '0; ch_len = '0; ch_bursts = '0; ch_gap = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  ch_data,  '0);
        chk("rst_valid", ch_valid, '0);
        chk("rst_busy",  ch_busy,  '0);
        chk("rst_done",  ch_done,  '0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Simultaneous starts on ch0 and ch2. A ch2 restart mid-burst and a
        // ch0 restart during its DONE cycle must both be ignored.
        e2v    = '{1, 1, 1, 1, 0, 0};
        e2d    = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0, 16'h0};
        e2done = '{0, 0, 0, 0, 1, 0};
        e0v    = '{1, 1, 1, 0, 0, 0};
        e0d    = '{16'd10, 16'd11, 16'd12, 16'd0, 16'd0, 16'd0};
        e0done = '{0, 0, 0, 1, 0, 0};
        e0busy = '{1, 1, 1, 1, 0, 0};
        cfg(0, 16'd10, 8'd3, 8'd1, 8'd0);
        cfg(2, 16'hFFFE, 8'd4, 8'd1, 8'd0);
        ch_start = 3'b101;
        @(posedge clk); #1;
        ch_start = '0;
        for (int c = 0; c < 6; c++) begin
            ch_start = '0;
            if (c == 1) begin cfg(2, 16'h1234, 8'd9, 8'd9, 8'd0); ch_start[2] = 1'b1; end
            if (c == 3) begin cfg(0, 16'h4321, 8'd5, 8'd1, 8'd0); ch_start[0] = 1'b1; end
            #1;
            chk($sformatf("par_c%0d_v2", c), 32'(ch_valid[2]), 32'(e2v[c]));
            if (e2v[c]) chk($sformatf("par_c%0d_d2", c), ch_data[2*DW +: DW], e2d[c]);
            chk($sformatf("par_c%0d_done2", c), 32'(ch_done[2]), 32'(e2done[c]));
            chk($sformatf("par_c%0d_v0", c), 32'(ch_valid[0]), 32'(e0v[c]));
            if (e0v[c]) chk($sformatf("par_c%0d_d0", c), ch_data[0 +: DW], e0d[c]);
            chk($sformatf("par_c%0d_done0", c), 32'(ch_done[0]), 32'(e0done[c]));
            chk($sformatf("par_c%0d_busy0", c), 32'(ch_busy[0]), 32'(e0busy[c]));
            @(posedge clk); #1;
        end
        ch_start = '0;

        // Async reset mid-burst: outputs drop before any clock edge.
        cfg(0, 16'd5, 8'd8, 8'd1, 8'd0);
        ch_start[0] = 1'b1;
        @(posedge clk); #1;
        ch_start[0] = 1'b0;
        @(posedge clk); #1;
        chk("ar_pre_data", ch_data[0 +: DW], 16'd6);
        #2 rst = 1'b1;
        #1;
        chk("ar_data",  ch_data,  '0);
        chk("ar_valid", ch_valid, '0);
        chk("ar_busy",  ch_busy,  '0);
        rst = 1'b0;
        @(posedge clk); #1;
        ch_start[0] = 1'b1;
        @(posedge clk); #1;
        ch_start[0] = 1'b0;
        chk("ar_restart_data", ch_data[0 +: DW], 16'd5);
        chk("ar_restart_valid", 32'(ch_valid[0]), 32'd1);
        @(posedge clk); #1;

        // Soft clear beats a same-cycle start and transfer, and acts at the edge.
        clr = 1'b1;
        cfg(1, 16'd77, 8'd2, 8'd1, 8'd0);
        ch_start[1] = 1'b1;
        #1;
        chk("clr_pre_valid", 32'(ch_valid[0]), 32'd1);
        @(posedge clk); #1;
        clr = 1'b0;
        ch_start[1] = 1'b0;
        chk("clr_data",  ch_data,  '0);
        chk("clr_valid", ch_valid, '0);
        chk("clr_busy",  ch_busy,  '0);
        chk("clr_done",  ch_done,  '0);
        cfg(0, 16'd5, 8'd2, 8'd1, 8'd0);
        ch_start[0] = 1'b1;
        @(posedge clk); #1;
        ch_start[0] = 1'b0;
        chk("clr_restart_data", ch_data[0 +: DW], 16'd5);
        n = 0;
        while (ch_busy[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clr_restart_finish", 32'(ch_busy[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
